// File: rtl/muldiv_sequencer.sv
// Iterative RV32M MUL/DIV sequencer: shift-add multiply and restoring
// divide, one bit per clock, with a core stall while an op is in flight.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy,
  output logic                  done,
  output logic                  stall
);

  localparam int W = DATA_WIDTH;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_DIV = 4'd8;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE
  } state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [W-1:0]         r_a;
  logic [W-1:0]         r_b;
  logic [W-1:0]         r_acc;
  logic [W:0]           r_rem;
  logic                 r_sign;
  logic [W-1:0]         r_result;
  logic                 r_busy;
  logic                 r_done;

  logic         w_is_mul;
  logic         w_is_div;
  logic         w_idle;
  logic [W-1:0] w_abs_a;
  logic [W-1:0] w_abs_b;
  logic [W-1:0] w_mul_sum;
  logic [W+1:0] w_trial;
  logic         w_neg;

  assign w_is_mul  = (alu_op == OP_MUL);
  assign w_is_div  = (alu_op == OP_DIV);
  assign w_idle    = (r_state == S_IDLE);
  assign w_abs_a   = operand_a[W-1] ? -operand_a : operand_a;
  assign w_abs_b   = operand_b[W-1] ? -operand_b : operand_b;
  assign w_mul_sum = r_acc + (r_b[0] ? r_a : '0);
  // Dividend bits enter the remainder from the top of the quotient register
  assign w_trial   = {r_rem, r_a[W-1]} - {2'b00, r_b};
  assign w_neg     = w_trial[W+1];

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;
  assign stall  = r_busy | (start & (w_is_mul | w_is_div) & w_idle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_sign   <= 1'b0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start && (w_is_mul || w_is_div)) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_rem <= '0;
            if (w_is_mul) begin
              r_a     <= operand_a;
              r_b     <= operand_b;
              r_busy  <= 1'b1;
              r_state <= S_MUL;
            end else begin
              r_a    <= w_abs_a;
              r_b    <= w_abs_b;
              r_sign <= operand_a[W-1] ^ operand_b[W-1];
              if (operand_b == '0) begin
                r_result <= '1;
                r_done   <= 1'b1;
                r_state  <= S_DONE;
              end else begin
                r_busy  <= 1'b1;
                r_state <= S_DIV;
              end
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_sum;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + CNT_WIDTH'(1);
          if (r_cnt == LAST) begin
            r_result <= w_mul_sum;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
          if (w_neg) begin
            r_rem <= {r_rem[W-1:0], r_a[W-1]};
            r_a   <= {r_a[W-2:0], 1'b0};
          end else begin
            r_rem <= w_trial[W:0];
            r_a   <= {r_a[W-2:0], 1'b1};
          end
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= r_sign ? -r_a : r_a;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases plus
// random ops against an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  alu_op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic        stall;

  int checks;
  int failures;

  muldiv_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .alu_op    (alu_op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    if (op == 4'd7) return a * b;
    if (b == 32'd0) return 32'hFFFF_FFFF;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
    return $signed(a) / $signed(b);
  endfunction

  // Edges after the acceptance edge until done is visible
  function automatic int model_lat(input logic [3:0] op,
                                   input logic [31:0] b);
    if (op == 4'd7) return 32;
    if (b == 32'd0) return 0;
    return 33;
  endfunction

  task automatic do_op(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input int poke);
    int n;
    int busy_cnt;
    logic [31:0] exp;
    int lat;
    exp = model(op, a, b);
    lat = model_lat(op, b);
    @(negedge clk);
    alu_op = op;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    #1 chk({tag, "_stall_req"}, {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    n = 0;
    busy_cnt = 0;
    while (!done && n < 200) begin
      if (busy) busy_cnt++;
      if (n == poke) begin
        start = 1'b1;
        alu_op = 4'd7;
        operand_a = 32'd99;
        operand_b = 32'd99;
      end else if (n == poke + 2) begin
        start = 1'b1;
        alu_op = 4'd0;
      end else begin
        start = 1'b0;
      end
      if (n == poke) begin
        #1 chk({tag, "_stall_busy"}, {31'd0, stall}, 32'd1);
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_busy_cycles"}, busy_cnt, lat);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_result"}, result, exp);
    start = 1'b1;
    alu_op = 4'd7;
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_no_accept_in_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_stall_idle_req"}, {31'd0, stall}, 32'd1);
    start = 1'b0;
    alu_op = 4'd0;
    #1 chk({tag, "_hold"}, result, exp);
  endtask

  initial begin
    bit seen_done;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    alu_op = 4'd0;
    operand_a = '0;
    operand_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("mul_7x6", 4'd7, 32'd7, 32'd6, -10);
    chk("mul_42", result, 32'd42);
    do_op("mul_m1", 4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -10);
    chk("mul_m1_one", result, 32'd1);
    do_op("div_m7_2", 4'd8, 32'hFFFF_FFF9, 32'd2, -10);
    chk("div_m3", result, 32'hFFFF_FFFD);
    do_op("div_ovf", 4'd8, 32'h8000_0000, 32'hFFFF_FFFF, -10);
    chk("div_ovf_val", result, 32'h8000_0000);
    do_op("div_zero", 4'd8, 32'd5, 32'd0, -10);
    do_op("mul_poke", 4'd7, 32'd7, 32'd6, 10);
    do_op("div_poke", 4'd8, 32'd1000, 32'hFFFF_FFF9, 5);

    @(negedge clk);
    start = 1'b1;
    alu_op = 4'd0;
    operand_a = 32'd3;
    operand_b = 32'd4;
    #1 chk("op0_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    chk("op0_busy", {31'd0, busy}, 32'd0);
    chk("op0_result", result, model(4'd8, 32'd1000, 32'hFFFF_FFF9));
    start = 1'b0;

    @(negedge clk);
    alu_op = 4'd8;
    operand_a = 32'hFFFF_FF9C;
    operand_b = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_result", result, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done = 1'b1;
    end
    chk("arst_no_done", {31'd0, seen_done}, 32'd0);
    do_op("mul_3x3", 4'd7, 32'd3, 32'd3, -10);
    chk("mul_9", result, 32'd9);

    for (int i = 0; i < 10; i++) begin
      logic [3:0] op;
      logic [31:0] a;
      logic [31:0] b;
      op = ($urandom_range(0, 1) == 0) ? 4'd7 : 4'd8;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      if (i == 7) b = 32'd0;
      do_op("rand", op, a, b, -10);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
